// File: rtl/gray_count_decoder.sv
// gray_count_decoder
//   Consumer of an upstream gray-coded counter. The gray bus is resynchronised
//   through a plain flop chain. Every change of the synced sample is checked
//   for a legal +1 gray step. The sample is converted to binary and extended
//   into a wider count. Illegal transitions are reported and counted.
//
// Parameters
//   WIDTH        width of gray_in / bin_out
//   EXT_WIDTH    width of ext_count (must exceed WIDTH)
//   SYNC_STAGES  synchroniser depth on gray_in (>= 2)
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   gray_in    gray-coded count from upstream (may be asynchronous)
//   clr        synchronous clear of ext_count and err_count
//   ready      high once the first reference sample has been captured
//   bin_out    binary value of the last accepted gray sample
//   ext_count  legal +1 steps since reset/clr, modulo 2^EXT_WIDTH
//   step       1-cycle pulse: legal +1 step accepted
//   wrap       1-cycle pulse: accepted step took bin_out from all-ones to 0
//   err        1-cycle pulse: illegal transition detected
//   err_count  illegal transitions since reset/clr, saturating at 255
//
// All outputs are registered; gray_in and clr reach them only through flops.

module gray_count_decoder #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned EXT_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clr,
  output logic                 ready,
  output logic [WIDTH-1:0]     bin_out,
  output logic [EXT_WIDTH-1:0] ext_count,
  output logic                 step,
  output logic                 wrap,
  output logic                 err,
  output logic [7:0]           err_count
);

  localparam int unsigned FW = $clog2(SYNC_STAGES) + 1;
  localparam logic [FW-1:0] FILL_LAST = FW'(SYNC_STAGES - 1);

  typedef enum logic [1:0] {
    FILL,
    PRIME,
    RUN,
    RESYNC
  } state_t;

  state_t               state_q, state_n;
  logic [FW-1:0]        fill_q, fill_n;
  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     gs;
  logic [WIDTH-1:0]     ref_q, ref_n;
  logic [WIDTH-1:0]     bin_q, bin_n;
  logic [EXT_WIDTH-1:0] ext_q, ext_n;
  logic [7:0]           errc_q, errc_n;
  logic                 ready_q, ready_n;
  logic                 step_q, step_n;
  logic                 wrap_q, wrap_n;
  logic                 err_q, err_n;

  logic [WIDTH-1:0]     diff;
  logic                 one_bit;
  logic [WIDTH-1:0]     gs_bin;

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      b[WIDTH-1-i] = b[WIDTH-i] ^ g[WIDTH-1-i];
    end
    return b;
  endfunction

  assign gs = sync_q[SYNC_STAGES-1];

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign diff    = gs ^ ref_q;
  assign one_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
  assign gs_bin  = g2b(gs);

  always_comb begin
    state_n = state_q;
    fill_n  = fill_q;
    ref_n   = ref_q;
    bin_n   = bin_q;
    ext_n   = ext_q;
    errc_n  = errc_q;
    ready_n = ready_q;
    step_n  = 1'b0;
    wrap_n  = 1'b0;
    err_n   = 1'b0;

    case (state_q)
      FILL: begin
        // Let the synchroniser fill with real samples before trusting gs.
        if (fill_q == FILL_LAST) begin
          state_n = PRIME;
        end else begin
          fill_n = fill_q + FW'(1);
        end
      end

      PRIME: begin
        ref_n   = gs;
        bin_n   = gs_bin;
        ready_n = 1'b1;
        state_n = RUN;
      end

      RUN: begin
        if (diff != '0) begin
          if (one_bit && (gs_bin == bin_q + WIDTH'(1))) begin
            ref_n  = gs;
            bin_n  = gs_bin;
            step_n = 1'b1;
            wrap_n = (gs_bin == '0);
            ext_n  = ext_q + EXT_WIDTH'(1);
          end else begin
            err_n   = 1'b1;
            if (errc_q != '1) begin
              errc_n = errc_q + 8'd1;
            end
            state_n = RESYNC;
          end
        end
      end

      RESYNC: begin
        ref_n   = gs;
        bin_n   = gs_bin;
        state_n = RUN;
      end

      default: begin
        state_n = FILL;
      end
    endcase

    // Clear takes priority over the increments above; pulses are untouched.
    if (clr) begin
      ext_n  = '0;
      errc_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      state_q <= FILL;
      fill_q  <= '0;
      ref_q   <= '0;
      bin_q   <= '0;
      ext_q   <= '0;
      errc_q  <= '0;
      ready_q <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q[0] <= gray_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      state_q <= state_n;
      fill_q  <= fill_n;
      ref_q   <= ref_n;
      bin_q   <= bin_n;
      ext_q   <= ext_n;
      errc_q  <= errc_n;
      ready_q <= ready_n;
      step_q  <= step_n;
      wrap_q  <= wrap_n;
      err_q   <= err_n;
    end
  end

  assign ready     = ready_q;
  assign bin_out   = bin_q;
  assign ext_count = ext_q;
  assign step      = step_q;
  assign wrap      = wrap_q;
  assign err       = err_q;
  assign err_count = errc_q;

endmodule

// File: tb/tb_gray_count_decoder.sv
// tb_gray_count_decoder
//   Directed bench for gray_count_decoder (default parameters). Vectors hold a
//   gray value, the pulses expected while it settles and the resulting
//   register values; hand-written sequences cover clr, saturation, the full
//   wrap sweep and reset mid-operation.

module tb_gray_count_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  gray_in;
  logic        clr;
  logic        ready;
  logic [7:0]  bin_out;
  logic [15:0] ext_count;
  logic        step;
  logic        wrap;
  logic        err;
  logic [7:0]  err_count;

  gray_count_decoder #(
    .WIDTH       (8),
    .EXT_WIDTH   (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .clr       (clr),
    .ready     (ready),
    .bin_out   (bin_out),
    .ext_count (ext_count),
    .step      (step),
    .wrap      (wrap),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_step = 0;
  int n_err  = 0;
  int n_wrap = 0;
  int wrap_bin = -1;

  typedef struct {
    logic [7:0] g;
    int         st;
    int         er;
    int         bin;
    int         ext;
    int         errc;
  } vec_t;

  vec_t tv [12];

  function automatic logic [7:0] bin2gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance n cycles, sampling outputs on each falling edge.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (step) n_step++;
      if (err)  n_err++;
      if (wrap) begin
        n_wrap++;
        wrap_bin = int'(bin_out);
      end
    end
  endtask

  int s0, e0, w0;

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    clr = 1'b0;
    gray_in = 8'h00;

    //                 gray  st er bin ext errc
    tv[0]  = '{8'h01, 1, 0, 1, 1, 0};
    tv[1]  = '{8'h03, 1, 0, 2, 2, 0};
    tv[2]  = '{8'h02, 1, 0, 3, 3, 0};
    tv[3]  = '{8'h07, 0, 1, 5, 3, 1};   // two-bit jump
    tv[4]  = '{8'h05, 1, 0, 6, 4, 1};
    tv[5]  = '{8'h05, 0, 0, 6, 4, 1};   // no change
    tv[6]  = '{8'h04, 1, 0, 7, 5, 1};
    tv[7]  = '{8'h05, 0, 1, 6, 5, 2};   // backward single-bit
    tv[8]  = '{8'h07, 0, 1, 5, 5, 3};
    tv[9]  = '{8'h03, 0, 1, 2, 5, 4};
    tv[10] = '{8'h01, 0, 1, 1, 5, 5};   // 03 -> 01 backward
    tv[11] = '{8'h03, 1, 0, 2, 6, 5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(ready), 0);
    chk("rst_bin", int'(bin_out), 0);
    chk("rst_ext", int'(ext_count), 0);
    chk("rst_errc", int'(err_count), 0);
    chk("rst_pulses", int'({step, wrap, err}), 0);

    rst = 1'b0;
    run(2);
    chk("ready_early", int'(ready), 0);
    run(1);
    chk("ready_rise", int'(ready), 1);
    chk("prime_bin", int'(bin_out), 0);
    chk("prime_ext", int'(ext_count), 0);
    chk("prime_pulses", n_step + n_err + n_wrap, 0);

    foreach (tv[i]) begin
      s0 = n_step; e0 = n_err; w0 = n_wrap;
      gray_in = tv[i].g;
      run(4);
      chk($sformatf("v%0d_step", i), n_step - s0, tv[i].st);
      chk($sformatf("v%0d_err", i), n_err - e0, tv[i].er);
      chk($sformatf("v%0d_wrap", i), n_wrap - w0, 0);
      chk($sformatf("v%0d_bin", i), int'(bin_out), tv[i].bin);
      chk($sformatf("v%0d_ext", i), int'(ext_count), tv[i].ext);
      chk($sformatf("v%0d_errc", i), int'(err_count), tv[i].errc);
    end

    // clr coincident with an accepted step (gray 02 = bin 3)
    s0 = n_step;
    gray_in = 8'h02;
    run(2);
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    chk("clrstep_step", n_step - s0, 1);
    chk("clrstep_ext", int'(ext_count), 0);
    chk("clrstep_errc", int'(err_count), 0);
    chk("clrstep_bin", int'(bin_out), 3);

    // clr coincident with an error (02 -> 07 is a two-bit jump)
    run(1);
    chk("pre_clrerr_errc", int'(err_count), 0);
    e0 = n_err;
    gray_in = 8'h07;
    run(2);
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    chk("clrerr_err", n_err - e0, 1);
    chk("clrerr_errc", int'(err_count), 0);
    run(1);
    chk("clrerr_bin", int'(bin_out), 5);
    gray_in = 8'h05;
    run(4);
    chk("after_clr_ext", int'(ext_count), 1);
    chk("after_clr_bin", int'(bin_out), 6);

    // plain clr leaves bin_out alone
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    chk("clr_ext", int'(ext_count), 0);
    chk("clr_bin", int'(bin_out), 6);

    // 300 illegal jumps between 05 and 00 saturate err_count
    e0 = n_err;
    for (int k = 0; k < 300; k++) begin
      gray_in = (k % 2 == 0) ? 8'h00 : 8'h05;
      run(4);
      if (k == 253) chk("errc_254", int'(err_count), 254);
    end
    chk("sat_err_pulses", n_err - e0, 300);
    chk("sat_errc", int'(err_count), 255);
    chk("sat_ext", int'(ext_count), 0);
    chk("sat_bin", int'(bin_out), 6);

    // full sweep from a fresh reset
    rst = 1'b1;
    gray_in = 8'h00;
    run(2);
    rst = 1'b0;
    run(3);
    chk("sweep_ready", int'(ready), 1);
    s0 = n_step; e0 = n_err; w0 = n_wrap; wrap_bin = -1;
    for (int i = 1; i <= 256; i++) begin
      gray_in = bin2gray(8'(i));
      run(3);
    end
    run(4);
    chk("sweep_steps", n_step - s0, 256);
    chk("sweep_wraps", n_wrap - w0, 1);
    chk("sweep_wrap_bin", wrap_bin, 0);
    chk("sweep_errs", n_err - e0, 0);
    chk("sweep_ext", int'(ext_count), 256);
    chk("sweep_bin", int'(bin_out), 0);

    // reset mid-sweep, re-prime on the held value
    for (int i = 1; i <= 40; i++) begin
      gray_in = bin2gray(8'(i));
      run(2);
    end
    run(2);
    chk("mid_ext", int'(ext_count), 296);
    chk("mid_bin", int'(bin_out), 40);
    rst = 1'b1;
    run(1);
    chk("midrst_ready", int'(ready), 0);
    chk("midrst_bin", int'(bin_out), 0);
    chk("midrst_ext", int'(ext_count), 0);
    chk("midrst_errc", int'(err_count), 0);
    chk("midrst_pulses", int'({step, wrap, err}), 0);
    rst = 1'b0;
    s0 = n_step; e0 = n_err;
    run(2);
    chk("reprime_ready_early", int'(ready), 0);
    run(1);
    chk("reprime_ready", int'(ready), 1);
    chk("reprime_bin", int'(bin_out), 40);
    run(2);
    chk("reprime_ext", int'(ext_count), 0);
    chk("reprime_pulses", (n_step - s0) + (n_err - e0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
